// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read-side and output-stream signals of fifo_rd_stream.
// master = the adapter, slave = the FIFO and the downstream consumer together.
interface fifo_rd_stream_if #(
  parameter int DW = 8
);
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: pops sm_sync_fifo into a 3-entry skid buffer and emits a valid/ready stream with m_last.
// Define FIFO_RD_COMB_OUT_EN when the FIFO data_out is combinational (same-cycle read data).
module fifo_rd_stream #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rd_stream_if.master bus
);
  localparam int              BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(PKT_LEN - 1);

  logic [DW-1:0] buf_mem [3];
  logic [1:0]    wr_ptr, rd_ptr, occ;
  logic [BW-1:0] beat_cnt;
  logic [2:0]    pending;
  logic          pop, capture, hs, valid, last;
  logic [DW-1:0] data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef FIFO_RD_COMB_OUT_EN
  assign pending = {1'b0, occ};
  assign capture = pop;
`else
  // One word can be on the FIFO output register; reserve its slot.
  logic inflight;
  assign pending = {1'b0, occ} + {2'b00, inflight};
  assign capture = inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= pop;
  end
`endif

  // Pop decision uses registered state only, never m_ready.
  assign pop   = !rst && !bus.fifo_empty && (pending < 3'd3);
  assign valid = (occ != 2'd0);
  assign last  = valid && (beat_cnt == LAST_BEAT);
  assign hs    = valid && bus.m_ready;

  always_comb begin
    data = buf_mem[0];
    case (rd_ptr)
      2'd1:    data = buf_mem[1];
      2'd2:    data = buf_mem[2];
      default: ;
    endcase
  end

  assign bus.fifo_rd_en = pop;
  assign bus.m_valid    = valid;
  assign bus.m_data     = data;
  assign bus.m_last     = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
      wr_ptr <= 2'd0;
    end else if (capture) begin
      buf_mem[wr_ptr] <= bus.fifo_data;
      wr_ptr          <= ptr_inc(wr_ptr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= 2'd0;
      beat_cnt <= '0;
    end else if (hs) begin
      rd_ptr   <= ptr_inc(rd_ptr);
      beat_cnt <= last ? '0 : beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
    end else begin
      case ({capture, hs})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural sm_sync_fifo model and PKT_LEN=1 side instance.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

`ifdef FIFO_RD_COMB_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  fifo_rd_stream_if #(.DW(8)) bus  ();
  fifo_rd_stream_if #(.DW(8)) bus1 ();

  fifo_rd_stream #(.DW(8), .PKT_LEN(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fifo_rd_stream #(.DW(8), .PKT_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Behavioural FIFO, depth 16
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fmem [16];
  logic [7:0] fdata_q;
  int         fwp, frp, fcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fwp <= 0; frp <= 0; fcnt <= 0; fdata_q <= 8'h00;
    end else begin
      if (push) begin
        fmem[fwp] <= push_data;
        fwp       <= (fwp + 1) % 16;
      end
      if (bus.fifo_rd_en && fcnt > 0) begin
        fdata_q <= fmem[frp];
        frp     <= (frp + 1) % 16;
      end
      fcnt <= fcnt + (push ? 1 : 0) - ((bus.fifo_rd_en && fcnt > 0) ? 1 : 0);
    end
  end

  assign bus.fifo_empty = (fcnt == 0);
`ifdef FIFO_RD_COMB_OUT_EN
  assign bus.fifo_data = fmem[frp];
`else
  assign bus.fifo_data = fdata_q;
`endif

  int pops = 0;
  int hss  = 0;
  always @(posedge clk) begin
    if (!rst && bus.fifo_rd_en) pops++;
    if (!rst && bus.m_valid && bus.m_ready) hss++;
  end

  logic [7:0] exp_q [$];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; push = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push = 1'b1; push_data = base + 8'(i);
      exp_q.push_back(base + 8'(i));
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got [$];
    rst = 1'b1;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL por_valid: got %b expected 0", bus.m_valid); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL por_last: got %b expected 0", bus.m_last); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL por_data: got %h expected 00", bus.m_data); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL por_rd_en: got %b expected 0", bus.fifo_rd_en); end
    do_reset();
    push_words(8'hE0, 2);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b expected 1", bus.m_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.m_valid); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL mid_rst_last: got %b expected 0", bus.m_last); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", bus.m_data); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en: got %b expected 0", bus.fifo_rd_en); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    push_words(8'h10, 2);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 2; c++) begin
      @(negedge clk);
      #1;
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL post_rst_count: got %0d words expected 2", got.size());
    end else begin
      checks++; if (got[0] !== 8'h10) begin errors++; $display("FAIL post_rst_w0: got %h expected 10", got[0]); end
      checks++; if (got[1] !== 8'h11) begin errors++; $display("FAIL post_rst_w1: got %h expected 11", got[1]); end
    end
  endtask

  task automatic test_single();
    int pulses = 0, pop_c = -1, val_c = -1;
    logic [7:0] vdata = 8'h00;
    logic vlast = 1'b0;
    do_reset();
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      push = (c == 0); push_data = 8'hA5;
      #1;
      if (bus.fifo_rd_en) begin pulses++; pop_c = c; end
      if (bus.m_valid && val_c < 0) begin val_c = c; vdata = bus.m_data; vlast = bus.m_last; end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pops: got %0d expected 1", pulses); end
    checks++; if (val_c - pop_c != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", val_c - pop_c, LAT); end
    checks++; if (vdata !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", vdata); end
    checks++; if (vlast !== 1'b0) begin errors++; $display("FAIL single_last: got %b expected 0", vlast); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus.m_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    push_words(8'h00, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.m_ready = 1'b1;
      #1;
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.m_valid); end
      checks++; if (bus.m_data !== 8'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, bus.m_data, 8'(i)); end
      checks++; if (bus.m_last !== ((i % 4) == 3)) begin errors++; $display("FAIL stream_last[%0d]: got %b expected %b", i, bus.m_last, (i % 4) == 3); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b expected 0", bus.m_valid); end
  endtask

  task automatic test_backpressure();
    int p0;
    do_reset();
    p0 = pops;
    push_words(8'h00, 16);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en[%0d]: got %b expected 0", c, bus.fifo_rd_en); end
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.m_valid); end
      checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 00", c, bus.m_data); end
    end
    checks++; if (pops - p0 != 3) begin errors++; $display("FAIL bp_pops: got %0d expected 3", pops - p0); end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      bus.m_ready = 1'b1;
      #1;
      if (bus.m_valid) begin
        checks++; if (bus.m_data !== exp_q[0]) begin errors++; $display("FAIL bp_order: got %h expected %h", bus.m_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int p0, h0, n_hs = 0, outst;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;
    do_reset();
    p0 = pops; h0 = hss;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bus.m_ready = ($urandom_range(0, 99) < 40);
      push = (fcnt < 15) && ($urandom_range(0, 1) == 1);
      push_data = 8'($urandom);
      if (push) exp_q.push_back(push_data);
      #1;
      outst = (pops - p0) - (hss - h0);
      checks++; if (outst > 3 || outst < 0) begin errors++; $display("FAIL rnd_occupancy[%0d]: got %0d expected 0..3", c, outst); end
      if (prev_stall) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
          errors++; $display("FAIL rnd_stall[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b", c, bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra[%0d]: got %h expected none", c, bus.m_data);
        end else begin
          if (bus.m_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, bus.m_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        checks++; if (bus.m_last !== ((n_hs % 4) == 3)) begin errors++; $display("FAIL rnd_last[%0d]: got %b expected %b", c, bus.m_last, (n_hs % 4) == 3); end
        n_hs++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      push = 1'b0; bus.m_ready = 1'b1;
      #1;
      if (bus.m_valid) begin
        checks++; if (bus.m_data !== exp_q[0]) begin errors++; $display("FAIL rnd_drain_data: got %h expected %h", bus.m_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    push = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_pkt1();
    int vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus1.fifo_empty = ($urandom_range(0, 1) == 1);
      bus1.fifo_data  = 8'($urandom);
      bus1.m_ready    = ($urandom_range(0, 1) == 1);
      #1;
      if (bus1.m_valid) vcnt++;
      checks++; if (bus1.m_last !== bus1.m_valid) begin errors++; $display("FAIL pkt1_last[%0d]: got %b expected %b", c, bus1.m_last, bus1.m_valid); end
    end
    checks++; if (vcnt == 0) begin errors++; $display("FAIL pkt1_traffic: got %0d valid cycles expected >0", vcnt); end
  endtask

  initial begin
    bus.m_ready     = 1'b0;
    bus1.fifo_empty = 1'b1;
    bus1.fifo_data  = 8'h00;
    bus1.m_ready    = 1'b0;
    #1;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_pkt1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter that sits directly downstream of the team's synchronous FIFO (`sm_sync_fifo`). It drives the FIFO's `rd_en` from `empty`, absorbs the FIFO read latency in a 3-entry output buffer, and presents the words as a valid/ready stream. It also marks packet boundaries with `m_last` every `PKT_LEN` accepted words. There is no combinational path from `m_ready` to `fifo_rd_en`, yet sustained throughput is 1 word/cycle.

## Interface
- `DW`, default 8: data width; must equal the FIFO `DW`.
- `PKT_LEN`, default 4: words per packet; `m_last` marks word `PKT_LEN-1`; legal range 1..256.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `fifo_empty`, input, 1: FIFO `empty` flag.
- `fifo_rd_en`, output, 1: pop strobe to FIFO `rd_en`.
- `fifo_data`, input, DW: FIFO `data_out`.
- `m_valid`, output, 1: a word is presented on `m_data`.
- `m_ready`, input, 1: downstream accepts; a handshake is `m_valid & m_ready` at a rising edge.
- `m_data`, output, DW: presented word.
- `m_last`, output, 1: presented word is the last of its packet.

## Operation
- **State**
  - `buf[0..2]`, DW each.
  - `wr_ptr` and `rd_ptr`, 2 bits each, counting 0→1→2→0 (wrap at 2, never 3).
  - `occ`, 2 bits, 0..3.
  - `inflight`, 1 bit, registered mode only.
  - `beat_cnt`, width `$clog2(PKT_LEN)` (minimum 1 bit).
- **Pop rule**: `fifo_rd_en = !rst & !fifo_empty & (occ + inflight < 3)`. The rule is purely combinational from registers and `fifo_empty`; it never depends on `m_ready`.
- **Capture**: when a FIFO word becomes valid (see Timing), it is written to `buf[wr_ptr]` and `wr_ptr` advances.
- **Outputs**
  - `m_valid = (occ != 0)`.
  - `m_data = buf[rd_ptr]`.
  - `m_last = m_valid & (beat_cnt == PKT_LEN-1)`.
- **Handshake**: on a handshake, `rd_ptr` advances. `beat_cnt` then increments, or wraps to 0 if `m_last` was 1.
- **Occupancy**:
  - `occ` increases by 1 on a capture without a handshake.
  - `occ` decreases by 1 on a handshake without a capture.
  - `occ` is unchanged when both or neither occur.
- **Ordering**: words leave in exact FIFO order. None are dropped or duplicated.
- **Stall rule**: while `m_valid & !m_ready`, `m_data` and `m_last` hold stable. `m_valid` never deasserts without a handshake.
- **Overflow is impossible by construction**: `occ + inflight ≤ 3` always. The bench asserts this.
- **`PKT_LEN = 1`**: `m_last = m_valid` on every word.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - `occ`, `wr_ptr`, `rd_ptr`, `inflight` and `beat_cnt` are 0; `buf` is all zeros.
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0, `fifo_rd_en` = 0.
- **Reset mid-operation**: all buffered and in-flight words are discarded. The FIFO must be reset in the same cycle, so no FIFO word is lost unaccounted.
- **First output**
  - Registered FIFO read: pop in cycle t, `fifo_data` sampled at the edge ending cycle t+1, `m_valid` = 1 in cycle t+2.
  - Combinational FIFO read (see Configuration): pop in cycle t, `fifo_data` sampled at the edge ending cycle t, `m_valid` = 1 in cycle t+1.
- **Steady state**: with `fifo_empty` = 0 and `m_ready` held at 1, one handshake per cycle with no bubbles after the first output.
- **Backpressure**
  - With `m_ready` = 0, at most 3 words are buffered; `fifo_rd_en` stays 0 until a slot frees.
  - After `m_ready` rises, pops resume in the same cycle the slot frees at the edge. `occ` is evaluated after that edge.
- **`fifo_empty` asserting with a word in flight**: the in-flight word is still captured.

## Configuration
- `FIFO_RD_COMB_OUT_EN`
  - Defined: the FIFO `data_out` is combinational, valid in the same cycle as `rd_en`. `inflight` is removed (treated as 0), and capture occurs on the pop edge.
  - Undefined (default): `data_out` is registered with 1-cycle latency. Capture occurs on the edge after the pop, tracked by `inflight`.
  - The setting must match the FIFO build.

## Test plan
- **Reset values**: assert `rst` mid-stream with `occ` = 2 → all outputs 0 within the same cycle. After release, the next FIFO words 0x10, 0x11 emerge first and in order.
- **Single word**: push 0xA5 into the empty FIFO with `m_ready` = 1 → `fifo_rd_en` pulses once, and `m_valid` with `m_data` = 0xA5 appears 2 cycles after the pop (1 cycle with `FIFO_RD_COMB_OUT_EN`).
- **Streaming**: FIFO preloaded with 0x00..0x0F and `m_ready` = 1 → 16 handshakes on consecutive cycles, data 0x00..0x0F, `m_last` on 0x03, 0x07, 0x0B, 0x0F (`PKT_LEN` = 4).
- **Backpressure**: `m_ready` = 0 for 10 cycles with the FIFO full → exactly 3 pops, then `fifo_rd_en` = 0. `m_data` holds 0x00 stable. After `m_ready` = 1, the order 0x00, 0x01, 0x02, ... is intact.
- **Random**: 40% `m_ready` and random FIFO pushes for 1000 cycles → a scoreboard matches every word. `occ + inflight ≤ 3` always, and `m_last` fires every 4th handshake.
- **`PKT_LEN` = 1**: any traffic → `m_last` equals `m_valid` on every cycle.
